// File: rtl/ram_sp_param.sv
// Parametrised single-port RAM with registered read, per-access ack and a post-reset self-clear.
// Optional feature macro: RAM_PARITY_EN (stores an even-parity bit per word, flags read mismatches).
module ram_sp_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              select,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              ack,
    output logic              busy,
    output logic              parity_err
);

`ifdef RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [MEM_W-1:0]  r_mem [DEPTH];

    logic              w_in_range;
    logic              w_clr_last;
    logic              w_access;
    logic              w_rd;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [MEM_W-1:0]  w_mem_wdata;
    logic [MEM_W-1:0]  w_wr_word;
    logic [MEM_W-1:0]  w_rd_word;

    assign w_in_range = 32'(address) < 32'(DEPTH);
    assign w_clr_last = (r_clr_ptr == ADDR_W'(DEPTH - 1));
    assign w_rd       = w_access & ~write;
    assign w_rd_word  = r_mem[address];

`ifdef RAM_PARITY_EN
    assign w_wr_word = {^data_in, data_in};
`else
    assign w_wr_word = data_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_CLEAR) begin
                r_clr_ptr <= w_clr_last ? '0 : r_clr_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_CLEAR: if (w_clr_last) w_next = S_IDLE;
            S_IDLE:  w_next = S_IDLE;
            default: w_next = S_CLEAR;
        endcase
    end

    // The clear sequencer owns the single write port until the array is zeroed.
    always_comb begin
        busy        = 1'b1;
        w_access    = 1'b0;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_clr_ptr;
        w_mem_wdata = '0;
        case (r_state)
            S_IDLE: begin
                busy        = 1'b0;
                w_access    = select;
                w_mem_we    = select & write & w_in_range;
                w_mem_addr  = address;
                w_mem_wdata = w_wr_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            ack      <= 1'b0;
        end else begin
            ack <= w_access;
            if (w_rd) begin
                data_out <= w_in_range ? w_rd_word[DATA_W-1:0] : '0;
            end
        end
    end

`ifdef RAM_PARITY_EN
    logic r_perr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else if (w_rd) begin
            r_perr <= w_in_range & (^w_rd_word);
        end else if (w_access) begin
            r_perr <= 1'b0;
        end
    end

    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sp_param.sv
// Directed bench for ram_sp_param: reset/clear timing, busy lockout, back-to-back access,
// fill/random readback, reset mid-clear, out-of-range on a small instance, and parity.
module tb_ram_sp_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       select = 1'b0;
    logic       write = 1'b0;
    logic [9:0] address = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       ack;
    logic       busy;
    logic       parity_err;

    logic       s_select = 1'b0;
    logic       s_write = 1'b0;
    logic [3:0] s_address = '0;
    logic [7:0] s_data_in = '0;
    logic [7:0] s_data_out;
    logic       s_ack;
    logic       s_busy;
    logic       s_parity_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_sp_param dut (
        .clk        (clk),
        .rst        (rst),
        .select     (select),
        .write      (write),
        .address    (address),
        .data_in    (data_in),
        .data_out   (data_out),
        .ack        (ack),
        .busy       (busy),
        .parity_err (parity_err)
    );

    ram_sp_param #(.DATA_W(8), .ADDR_W(4), .DEPTH(12)) u_small (
        .clk        (clk),
        .rst        (rst),
        .select     (s_select),
        .write      (s_write),
        .address    (s_address),
        .data_in    (s_data_in),
        .data_out   (s_data_out),
        .ack        (s_ack),
        .busy       (s_busy),
        .parity_err (s_parity_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [9:0] a, input logic [7:0] d);
        select  = 1'b1;
        write   = w;
        address = a;
        data_in = d;
        tick();
    endtask

    task automatic idle();
        select = 1'b0;
        write  = 1'b0;
        tick();
    endtask

    task automatic sdrive(input logic w, input logic [3:0] a, input logic [7:0] d);
        s_select  = 1'b1;
        s_write   = w;
        s_address = a;
        s_data_in = d;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        logic seen_ack;
        logic [9:0] a;

        // Reset values
        #1 rst = 1'b1;
        repeat (3) tick();
        check("rst_busy", busy, 1);
        check("rst_ack", ack, 0);
        check("rst_data", data_out, 8'h00);
        check("rst_perr", parity_err, 0);

        // Release with a write to 5 held on the bus for the whole clear
        select = 1'b1; write = 1'b1; address = 10'd5; data_in = 8'hAA;
        rst = 1'b0;
        n = 0; seen_ack = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            n++;
            if (ack) seen_ack = 1'b1;
            if (!busy) break;
        end
        select = 1'b0; write = 1'b0;
        check("clear_cycles", n, 1024);
        check("busy_no_ack", seen_ack, 0);
        check("small_clear_done", s_busy, 0);

        // Back-to-back on address 7
        drive(1'b1, 10'd7, 8'h3C); check("b2b_ack0", ack, 1);
        drive(1'b0, 10'd7, 8'h00); check("b2b_ack1", ack, 1); check("b2b_rd0", data_out, 8'h3C);
        drive(1'b1, 10'd7, 8'h55); check("b2b_ack2", ack, 1); check("b2b_hold", data_out, 8'h3C);
        drive(1'b0, 10'd7, 8'h00); check("b2b_ack3", ack, 1); check("b2b_rd1", data_out, 8'h55);
        idle(); check("idle_no_ack", ack, 0); check("idle_hold", data_out, 8'h55);

        // Busy-time write to 5 was dropped; cleared words read zero
        drive(1'b0, 10'd5, 8'h00); check("busy_wr_dropped", data_out, 8'h00); check("rd5_ack", ack, 1);
        drive(1'b0, 10'd0, 8'h00); check("clr_rd0", data_out, 8'h00);
        drive(1'b0, 10'd511, 8'h00); check("clr_rd511", data_out, 8'h00);
        drive(1'b0, 10'd1023, 8'h00); check("clr_rd1023", data_out, 8'h00);
        idle();

        // Fill and random readback
        for (int k = 0; k < 1024; k++) begin
            drive(1'b1, 10'(k), 8'((2 * k) % 256));
            check("fill_ack", ack, 1);
        end
        idle();
        void'($urandom(35));
        for (int i = 0; i < 1000; i++) begin
            a = 10'($urandom_range(1023, 0));
            drive(1'b0, a, 8'h00);
            check("rand_ack", ack, 1);
            check("rand_data", data_out, (2 * 32'(a)) % 256);
            check("rand_perr", parity_err, 0);
        end
        idle();

        // Reset lands mid-cycle on a pending read: no ack, immediate busy
        select = 1'b1; write = 1'b0; address = 10'd10;
        #3 rst = 1'b1;
        #1 check("inflight_busy", busy, 1);
        check("inflight_data", data_out, 8'h00);
        tick();
        check("inflight_no_ack", ack, 0);
        select = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset again at clear cycle 300
        repeat (300) tick();
        check("mid_clear_busy", busy, 1);
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            n++;
            if (!busy) break;
        end
        check("restart_cycles", n, 1024);
        drive(1'b1, 10'd3, 8'hF1);
        drive(1'b0, 10'd3, 8'h00); check("post_rd3", data_out, 8'hF1);
        drive(1'b0, 10'd100, 8'h00); check("post_rd100", data_out, 8'h00);
        drive(1'b0, 10'd1023, 8'h00); check("post_rd1023", data_out, 8'h00);
        idle();

        // Out-of-range on a 12-word instance
        sdrive(1'b1, 4'd11, 8'h44); check("s_wr11_ack", s_ack, 1);
        sdrive(1'b0, 4'd11, 8'h00); check("s_rd11", s_data_out, 8'h44);
        sdrive(1'b1, 4'd13, 8'h77); check("s_oor_wr_ack", s_ack, 1); check("s_oor_wr_hold", s_data_out, 8'h44);
        sdrive(1'b0, 4'd13, 8'h00); check("s_oor_rd_ack", s_ack, 1); check("s_oor_rd", s_data_out, 8'h00);
        sdrive(1'b0, 4'd11, 8'h00); check("s_rd11_again", s_data_out, 8'h44);
        s_select = 1'b0;

        // Parity
        drive(1'b1, 10'd9, 8'h0F);
        idle();
`ifdef RAM_PARITY_EN
        dut.r_mem[9][0] = ~dut.r_mem[9][0];
        drive(1'b0, 10'd9, 8'h00);
        check("par_ack", ack, 1);
        check("par_err", parity_err, 1);
        check("par_data", data_out, 8'h0E);
`else
        drive(1'b0, 10'd9, 8'h00);
        check("par_ack", ack, 1);
        check("par_err", parity_err, 0);
        check("par_data", data_out, 8'h0F);
`endif
        drive(1'b0, 10'd10, 8'h00);
        check("par_clean_ack", ack, 1);
        check("par_clean", parity_err, 0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
